sof_gen_param: RTL and testbench

SOF_GEN_PARAM -- requirements
Module: sof_gen_param

---
 rtl/sof_gen_param.sv | 124 ++++++++++++
 tb/tb_sof_gen_param.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sof_gen_param.sv
// SOF frame generator: sends NUM_SLOTS pattern slots of SLOT_CLKS clocks each,
// then a TAIL_CLKS idle-level guard, repeated back-to-back repeat_n times.
module sof_gen_param #(
    parameter int                   SLOT_CLKS       = 16,
    parameter int                   NUM_SLOTS       = 8,
    parameter int                   TAIL_CLKS       = 2,
    parameter logic [NUM_SLOTS-1:0] DEFAULT_PATTERN = NUM_SLOTS'(8'b1101_1110)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 pattern_sel,
    input  logic [NUM_SLOTS-1:0] pattern_in,
    input  logic [3:0]           repeat_n,
    input  logic                 abort,
    output logic                 sof,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted
);

    // One cycle counter serves both slot and tail phases, so size it for the longer one.
    localparam int CYC_MAX = (SLOT_CLKS > TAIL_CLKS) ? SLOT_CLKS : TAIL_CLKS;
    localparam int CYC_W   = $clog2(CYC_MAX);
    localparam int SLOT_W  = $clog2(NUM_SLOTS);

    localparam logic [CYC_W-1:0]  SLOT_LAST = CYC_W'(SLOT_CLKS - 1);
    localparam logic [CYC_W-1:0]  TAIL_LAST = CYC_W'((TAIL_CLKS > 0) ? TAIL_CLKS - 1 : 0);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SLOT,
        TAIL
    } state_t;

    state_t               state;
    logic [CYC_W-1:0]     cyc;
    logic [SLOT_W-1:0]    slot;
    logic [SLOT_W-1:0]    slot_nxt;
    logic [NUM_SLOTS-1:0] pat;
    logic [3:0]           rep;
    logic                 frame_end;

    assign slot_nxt = slot + SLOT_W'(1);

    // Last cycle of a frame: end of the tail, or end of the last slot when there is no tail.
    always_comb begin
        frame_end = 1'b0;
        if (state == TAIL && cyc == TAIL_LAST)
            frame_end = 1'b1;
        if (state == SLOT && cyc == SLOT_LAST && slot == LAST_SLOT && TAIL_CLKS == 0)
            frame_end = 1'b1;
    end

    // NOTE: all state and outputs update with <= so every branch sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sof     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
            cyc     <= '0;
            slot    <= '0;
            pat     <= DEFAULT_PATTERN;
            rep     <= 4'd1;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            // Abort is checked first so it wins over completion on the final frame cycle.
            if (state != IDLE && abort) begin
                state   <= IDLE;
                sof     <= 1'b1;
                busy    <= 1'b0;
                aborted <= 1'b1;
            end else if (frame_end) begin
                cyc  <= '0;
                slot <= '0;
                if (rep > 4'd1) begin
                    rep   <= rep - 4'd1;
                    state <= SLOT;
                    sof   <= pat[0];
                end else begin
                    state <= IDLE;
                    sof   <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            pat   <= pattern_sel ? pattern_in : DEFAULT_PATTERN;
                            rep   <= (repeat_n == 4'd0) ? 4'd1 : repeat_n;
                            cyc   <= '0;
                            slot  <= '0;
                            state <= SLOT;
                            busy  <= 1'b1;
                            sof   <= pattern_sel ? pattern_in[0] : DEFAULT_PATTERN[0];
                        end
                    end
                    SLOT: begin
                        if (cyc == SLOT_LAST) begin
                            cyc <= '0;
                            if (slot == LAST_SLOT) begin
                                state <= TAIL;
                                sof   <= 1'b1;
                            end else begin
                                slot <= slot_nxt;
                                sof  <= pat[slot_nxt];
                            end
                        end else begin
                            cyc <= cyc + CYC_W'(1);
                        end
                    end
                    TAIL: cyc <= cyc + CYC_W'(1);
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sof_gen_param.sv
// Directed bench for sof_gen_param: a vector table of whole bursts at default
// parameters plus hand-written abort/reset sequences and a small-parameter instance.
`timescale 1ns/1ps
module tb_sof_gen_param;

    localparam int FRAME = 130;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, pattern_sel, abort;
    logic [7:0] pattern_in;
    logic [3:0] repeat_n;
    logic       sof, busy, done, aborted;

    logic       start2;
    logic       sof2, busy2, done2, aborted2;
    logic [3:0] pat2 = 4'b1010;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sof_gen_param dut (
        .clk(clk), .rst(rst), .start(start), .pattern_sel(pattern_sel),
        .pattern_in(pattern_in), .repeat_n(repeat_n), .abort(abort),
        .sof(sof), .busy(busy), .done(done), .aborted(aborted)
    );

    sof_gen_param #(
        .SLOT_CLKS(4), .NUM_SLOTS(4), .TAIL_CLKS(0), .DEFAULT_PATTERN(4'b1010)
    ) dut_small (
        .clk(clk), .rst(rst), .start(start2), .pattern_sel(1'b0),
        .pattern_in(4'h0), .repeat_n(4'd0), .abort(1'b0),
        .sof(sof2), .busy(busy2), .done(done2), .aborted(aborted2)
    );

    typedef struct {
        logic       sel;
        logic [7:0] pin;
        logic [3:0] rep;
        logic [7:0] exp_pat;
        int         frames;
        int         inj_cycle;
        logic       inj_sel;
        logic [7:0] inj_pin;
        logic [3:0] inj_rep;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic model_sof(input logic [7:0] p, input int o);
        if (o < 128) return p[o / 16];
        return 1'b1;
    endfunction

    // Runs one burst from IDLE; cycle 1 is the cycle after start is accepted.
    task automatic run_burst(input vec_t v, input int idx);
        int n;
        n = v.frames * FRAME;
        pattern_sel = v.sel;
        pattern_in  = v.pin;
        repeat_n    = v.rep;
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= n + 1; k++) begin
            check($sformatf("v%0d_sof_c%0d", idx, k), sof,
                  (k <= n) ? model_sof(v.exp_pat, (k - 1) % FRAME) : 1'b1);
            check($sformatf("v%0d_busy_c%0d", idx, k), busy, k <= n);
            check($sformatf("v%0d_done_c%0d", idx, k), done, k == n + 1);
            check($sformatf("v%0d_aborted_c%0d", idx, k), aborted, 1'b0);
            if (k == v.inj_cycle) begin
                start       = 1'b1;
                pattern_sel = v.inj_sel;
                pattern_in  = v.inj_pin;
                repeat_n    = v.inj_rep;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check($sformatf("v%0d_done_once", idx), done, 1'b0);
        check($sformatf("v%0d_idle_busy", idx), busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 8'h00, 4'd1, 8'hDE, 1, 0,   1'b0, 8'h00, 4'd0};
        vecs[1] = '{1'b1, 8'hA5, 4'd3, 8'hA5, 3, 0,   1'b0, 8'h00, 4'd0};
        vecs[2] = '{1'b0, 8'h00, 4'd1, 8'hDE, 1, 50,  1'b1, 8'h00, 4'd5};
        vecs[3] = '{1'b1, 8'h0F, 4'd0, 8'h0F, 1, 0,   1'b0, 8'h00, 4'd0};
        vecs[4] = '{1'b1, 8'h3C, 4'd2, 8'h3C, 2, 100, 1'b1, 8'hFF, 4'd9};

        rst = 1'b1;
        start = 1'b0; pattern_sel = 1'b0; pattern_in = 8'h00; repeat_n = 4'd1; abort = 1'b0;
        start2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sof", sof, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_aborted", aborted, 1'b0);
        check("rst_small_sof", sof2, 1'b1);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_burst(vecs[i], i);
            tick();
        end

        // Abort at cycle 40, then restart at cycle 45.
        pattern_sel = 1'b0; repeat_n = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (39) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort40_sof", sof, 1'b1);
        check("abort40_busy", busy, 1'b0);
        check("abort40_aborted", aborted, 1'b1);
        check("abort40_done", done, 1'b0);
        for (int k = 42; k <= 45; k++) begin
            tick();
            check($sformatf("abort40_quiet_aborted_c%0d", k), aborted, 1'b0);
            check($sformatf("abort40_quiet_done_c%0d", k), done, 1'b0);
            check($sformatf("abort40_quiet_busy_c%0d", k), busy, 1'b0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart46_busy", busy, 1'b1);
        check("restart46_sof", sof, 1'b0);
        for (int k = 47; k <= 177; k++) begin
            tick();
            check($sformatf("restart_done_c%0d", k), done, k == 176);
        end

        // Abort on the final frame cycle beats completion.
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (129) tick();
        check("final_cycle_busy", busy, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("final_abort_aborted", aborted, 1'b1);
        check("final_abort_done", done, 1'b0);
        check("final_abort_busy", busy, 1'b0);
        tick();
        check("final_abort_late_done", done, 1'b0);
        check("final_abort_pulse", aborted, 1'b0);

        // Abort together with start in IDLE does nothing.
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        check("abort_start_busy", busy, 1'b0);
        check("abort_start_sof", sof, 1'b1);
        check("abort_start_aborted", aborted, 1'b0);
        check("abort_start_done", done, 1'b0);
        tick();
        check("abort_start_busy_later", busy, 1'b0);

        // Reset at cycle 70 of a burst.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (69) tick();
        check("pre_rst_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst70_sof_async", sof, 1'b1);
        check("rst70_busy_async", busy, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rst70_done_%0d", k), done, 1'b0);
            check($sformatf("rst70_aborted_%0d", k), aborted, 1'b0);
        end
        rst = 1'b0;
        run_burst(vecs[0], 9);
        tick();

        // Small configuration: 4 slots x 4 clocks, no tail, repeat_n=0.
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            check($sformatf("small_sof_c%0d", k), sof2, (k <= 16) ? pat2[(k - 1) / 4] : 1'b1);
            check($sformatf("small_busy_c%0d", k), busy2, k <= 16);
            check($sformatf("small_done_c%0d", k), done2, k == 17);
            tick();
        end
        check("small_done_once", done2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
